// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: serializer state encodings and the
// default baud divisor.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    UART_TX_IDLE  = 2'd0,
    UART_TX_START = 2'd1,
    UART_TX_DATA  = 2'd2,
    UART_TX_STOP  = 2'd3
  } uart_tx_state_e;

  // 100 MHz / 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with occupancy count; pushes while full and pops while
// empty are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign o_full    = r_count[PtrW];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO fed by the memory-stage write strobe, drained by an 8N1
// serializer onto a registered tx_line.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_fifo_write_en,
  input  logic [7:0]             uart_fifo_data,
  output logic                   tx_line,
  output logic                   tx_ready,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   tx_overflow
);

  localparam int unsigned       BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0]  BaudLast = BaudW'(CLKS_PER_BIT - 1);

  uart_tx_state_e   r_state, w_state_d;
  logic [BaudW-1:0] r_baud, w_baud_d;
  logic [2:0]       r_bit_idx, w_bit_idx_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_tx_line, w_tx_line_d;
  logic             r_overflow;
  logic             w_pop;
  logic [7:0]       w_fifo_data;
  logic             w_full;
  logic             w_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (uart_fifo_write_en),
    .i_data  (uart_fifo_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (tx_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= UART_TX_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx_line  <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_baud    <= w_baud_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
      r_tx_line <= w_tx_line_d;
      if (uart_fifo_write_en && w_full) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_baud_d    = r_baud;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_pop       = 1'b0;
    unique case (r_state)
      UART_TX_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_fifo_data;
          w_baud_d  = '0;
          w_state_d = UART_TX_START;
        end
      end
      UART_TX_START: begin
        if (r_baud == BaudLast) begin
          w_baud_d    = '0;
          w_bit_idx_d = '0;
          w_state_d   = UART_TX_DATA;
        end else begin
          w_baud_d = r_baud + BaudW'(1);
        end
      end
      UART_TX_DATA: begin
        if (r_baud == BaudLast) begin
          w_baud_d = '0;
          if (r_bit_idx == 3'd7) w_state_d = UART_TX_STOP;
          else                   w_bit_idx_d = r_bit_idx + 3'd1;
        end else begin
          w_baud_d = r_baud + BaudW'(1);
        end
      end
      UART_TX_STOP: begin
        if (r_baud == BaudLast) begin
          w_baud_d = '0;
          // Chain straight into the next frame when data is waiting.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_fifo_data;
            w_state_d = UART_TX_START;
          end else begin
            w_state_d = UART_TX_IDLE;
          end
        end else begin
          w_baud_d = r_baud + BaudW'(1);
        end
      end
      default: w_state_d = UART_TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_line_d = 1'b1;
    unique case (w_state_d)
      UART_TX_START: w_tx_line_d = 1'b0;
      UART_TX_DATA:  w_tx_line_d = w_shift_d[w_bit_idx_d];
      default:       w_tx_line_d = 1'b1;
    endcase
  end

  assign tx_line     = r_tx_line;
  assign tx_busy     = (r_state != UART_TX_IDLE);
  assign tx_ready    = !w_full;
  assign tx_overflow = r_overflow;

endmodule
